shift_add_pipe: RTL and testbench

//   Parametrised multi-stage shift-and-add scaler: y = x * prod_k(1 +/- 2^-S_k).

---
 rtl/shift_add_pipe_if.sv | 21 ++
 rtl/shift_add_pipe.sv | 94 +++++++++
 tb/tb_shift_add_pipe.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/shift_add_pipe_if.sv
// rtl/shift_add_pipe_if.sv - valid/ready sample stream into and out of shift_add_pipe
interface shift_add_pipe_if #(
   parameter int WIDTH = 38
);
   logic                    in_valid;
   logic                    in_ready;
   logic signed [WIDTH-1:0] data_i;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [WIDTH-1:0] data_o;

   modport master (
      output in_valid, data_i, out_ready,
      input  in_ready, out_valid, data_o
   );

   modport slave (
      input  in_valid, data_i, out_ready,
      output in_ready, out_valid, data_o
   );
endinterface

// File: rtl/shift_add_pipe.sv
// rtl/shift_add_pipe.sv - multi-stage shift-and-add constant-gain scaler, y = x * prod(1 +/- 2^-S_k)
// Saturation and the sticky overflow flag exist only when SHADD_SAT_EN is defined.
module shift_add_pipe #(
   parameter int                  WIDTH    = 38,
   parameter int                  STAGES   = 4,
   parameter logic [8*STAGES-1:0] SHIFTS   = {8'd2, 8'd4, 8'd8, 8'd16},
   parameter logic [7:0]          SUB_MASK = 8'd0
) (
   input  logic                   clk,
   input  logic                   rst,
   shift_add_pipe_if.slave        bus,
   output logic                   ovf_o
);

   logic [STAGES-1:0][WIDTH-1:0] data_q;
   logic [STAGES-1:0][WIDTH-1:0] data_d;
   logic [STAGES-1:0]            vld_q;
   logic [STAGES-1:0]            vld_d;
   logic                         adv;

   // The whole chain moves in lockstep; a stalled output freezes every stage.
   assign adv           = !vld_q[STAGES-1] || bus.out_ready;
   assign bus.in_ready  = adv;
   assign bus.out_valid = vld_q[STAGES-1];
   assign bus.data_o    = data_q[STAGES-1];

`ifdef SHADD_SAT_EN
   localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
   logic [STAGES-1:0] stage_ovf;
`endif

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int SH = int'(SHIFTS[8*k +: 8]);

      logic signed [WIDTH-1:0] src;
      logic                    src_v;

      if (k == 0) begin : g_first
         assign src   = bus.data_i;
         assign src_v = bus.in_valid;
      end else begin : g_next
         assign src   = data_q[k-1];
         assign src_v = vld_q[k-1];
      end

`ifdef SHADD_SAT_EN
      logic signed [WIDTH:0] ext;
      logic signed [WIDTH:0] sum;
      logic                  ovf;

      assign ext = {src[WIDTH-1], src};
      assign sum = SUB_MASK[k] ? (ext - (ext >>> SH)) : (ext + (ext >>> SH));
      assign ovf = (sum[WIDTH] != sum[WIDTH-1]);
      assign stage_ovf[k] = src_v && ovf;
      assign data_d[k] = ovf ? (sum[WIDTH] ? SAT_MIN : SAT_MAX) : sum[WIDTH-1:0];
`else
      // Wrapping keeps only the low WIDTH bits, so the extra sum bit is never needed.
      logic signed [WIDTH-1:0] term;

      assign term      = src >>> SH;
      assign data_d[k] = SUB_MASK[k] ? (src - term) : (src + term);
`endif

      assign vld_d[k] = src_v;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
         vld_q  <= '0;
      end else if (adv) begin
         data_q <= data_d;
         vld_q  <= vld_d;
      end
   end

`ifdef SHADD_SAT_EN
   logic ovf_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (adv && (|stage_ovf)) begin
         ovf_q <= 1'b1;
      end
   end

   assign ovf_o = ovf_q;
`else
   assign ovf_o = 1'b0;
`endif

endmodule

// File: tb/tb_shift_add_pipe.sv
// tb/tb_shift_add_pipe.sv - directed self-checking bench for shift_add_pipe
// Expected saturation results follow SHADD_SAT_EN as defined for the build.
module tb_shift_add_pipe;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   shift_add_pipe_if #(.WIDTH(38)) main_if ();
   shift_add_pipe_if #(.WIDTH(38)) one_if ();
   shift_add_pipe_if #(.WIDTH(8))  sat_if ();
   shift_add_pipe_if #(.WIDTH(8))  sub_if ();

   logic ovf_main, ovf_one, ovf_sat, ovf_sub;

   shift_add_pipe u_main (
      .clk(clk), .rst(rst), .bus(main_if), .ovf_o(ovf_main)
   );

   shift_add_pipe #(.WIDTH(38), .STAGES(1), .SHIFTS(8'd16), .SUB_MASK(8'd0)) u_one (
      .clk(clk), .rst(rst), .bus(one_if), .ovf_o(ovf_one)
   );

   shift_add_pipe #(.WIDTH(8), .STAGES(1), .SHIFTS(8'd1), .SUB_MASK(8'd0)) u_sat (
      .clk(clk), .rst(rst), .bus(sat_if), .ovf_o(ovf_sat)
   );

   shift_add_pipe #(.WIDTH(8), .STAGES(1), .SHIFTS(8'd1), .SUB_MASK(8'd1)) u_sub (
      .clk(clk), .rst(rst), .bus(sub_if), .ovf_o(ovf_sub)
   );

   task automatic check(input string tag, input logic signed [63:0] got,
                        input logic signed [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Default chain: stage 0 uses the low byte of SHIFTS, i.e. shifts 16, 8, 4, 2.
   function automatic logic signed [37:0] gold(input logic signed [37:0] x_in);
      int     sh_tab [4] = '{16, 8, 4, 2};
      longint x;
      logic signed [37:0] r;
      x = longint'(x_in);
      for (int k = 0; k < 4; k++) begin
         x = x + (x >>> sh_tab[k]);
         x = (x <<< 26) >>> 26;
      end
      r = x[37:0];
      return r;
   endfunction

   logic signed [37:0] samp [20];
   logic signed [37:0] src3 [8];
   logic signed [37:0] exp_q [$];
   logic signed [37:0] fresh;
   logic [63:0]        rnd;
   int                 n_in, n_out;

   initial begin
      main_if.in_valid = 1'b0; main_if.data_i = '0; main_if.out_ready = 1'b1;
      one_if.in_valid  = 1'b0; one_if.data_i  = '0; one_if.out_ready  = 1'b1;
      sat_if.in_valid  = 1'b0; sat_if.data_i  = '0; sat_if.out_ready  = 1'b1;
      sub_if.in_valid  = 1'b0; sub_if.data_i  = '0; sub_if.out_ready  = 1'b1;

      repeat (2) @(negedge clk);
      check("rst_out_valid", 64'(main_if.out_valid), 64'(0));
      check("rst_data_o", 64'(main_if.data_o), 64'(0));
      check("rst_in_ready", 64'(main_if.in_ready), 64'(1));
      check("rst_ovf", 64'(ovf_sat), 64'(0));
      rst = 1'b0;

      // Single stage, shift 16
      one_if.in_valid = 1'b1; one_if.data_i = 38'sd65536;
      @(negedge clk);
      check("one_valid0", 64'(one_if.out_valid), 64'(1));
      check("one_data0", 64'(one_if.data_o), 64'(65537));
      one_if.data_i = -38'sd65536;
      @(negedge clk);
      check("one_data1", 64'(one_if.data_o), -64'(65537));
      one_if.data_i = -38'sd1;
      @(negedge clk);
      check("one_data2", 64'(one_if.data_o), -64'(2));
      one_if.in_valid = 1'b0;
      @(negedge clk);
      check("one_drained", 64'(one_if.out_valid), 64'(0));

      // Back-to-back stream through the default 4-stage chain
      for (int i = 0; i < 20; i++) begin
         rnd = {$urandom(), $urandom()};
         samp[i] = rnd[37:0];
      end
      samp[0] = 38'sd65536;
      samp[1] = -38'sd1;
      for (int t = 0; t < 24; t++) begin
         @(negedge clk);
         if (t >= 4) begin
            check("stream_valid", 64'(main_if.out_valid), 64'(1));
            check("stream_data", 64'(main_if.data_o), 64'(gold(samp[t-4])));
         end
         main_if.in_valid = (t < 20);
         main_if.data_i   = (t < 20) ? samp[t] : '0;
      end
      main_if.in_valid = 1'b0;
      @(negedge clk);
      check("stream_drained", 64'(main_if.out_valid), 64'(0));

      // Backpressure: out_ready low for 6 cycles with a continuously valid source
      for (int i = 0; i < 8; i++) src3[i] = 38'(1000 * (i + 1) - 3000);
      n_in = 0; n_out = 0; exp_q.delete();
      for (int t = 0; t < 60 && n_out < 8; t++) begin
         @(negedge clk);
         main_if.out_ready = (t >= 6);
         main_if.in_valid  = (n_in < 8);
         main_if.data_i    = (n_in < 8) ? src3[n_in] : '0;
         #1;
         if (t < 6) check("stall_in_ready", 64'(main_if.in_ready), 64'(t < 4));
         if (t == 4 || t == 5) begin
            check("stall_out_valid", 64'(main_if.out_valid), 64'(1));
            check("stall_data_hold", 64'(main_if.data_o), 64'(gold(src3[0])));
         end
         if (main_if.out_valid && main_if.out_ready) begin
            if (exp_q.size() > 0) check("stall_order", 64'(main_if.data_o), 64'(exp_q.pop_front()));
            else check("stall_unexpected_out", 64'(1), 64'(0));
            n_out++;
         end
         if (main_if.in_valid && main_if.in_ready) begin
            exp_q.push_back(gold(src3[n_in]));
            n_in++;
         end
      end
      check("stall_count", 64'(n_out), 64'(8));
      main_if.out_ready = 1'b1;
      main_if.in_valid  = 1'b0;

      // Saturating / wrapping single stage, 8 bits, shift 1
      @(negedge clk);
      sat_if.in_valid = 1'b1; sat_if.data_i = 8'sd100;
      sub_if.in_valid = 1'b1; sub_if.data_i = -8'sd128;
      @(negedge clk);
`ifdef SHADD_SAT_EN
      check("sat_pos", 64'(sat_if.data_o), 64'(127));
      check("sat_ovf", 64'(ovf_sat), 64'(1));
`else
      check("wrap_pos", 64'(sat_if.data_o), -64'(106));
      check("wrap_ovf", 64'(ovf_sat), 64'(0));
`endif
      check("sub_neg", 64'(sub_if.data_o), -64'(64));
      sat_if.data_i = 8'sd1;
      sub_if.data_i = 8'sd1;
      @(negedge clk);
      check("sat_small", 64'(sat_if.data_o), 64'(1));
`ifdef SHADD_SAT_EN
      check("sat_ovf_sticky", 64'(ovf_sat), 64'(1));
`else
      check("wrap_ovf_zero", 64'(ovf_sat), 64'(0));
`endif
      check("sub_one", 64'(sub_if.data_o), 64'(1));
      sat_if.data_i = -8'sd100;
      sub_if.data_i = 8'sd127;
      @(negedge clk);
`ifdef SHADD_SAT_EN
      check("sat_neg", 64'(sat_if.data_o), -64'(128));
`else
      check("wrap_neg", 64'(sat_if.data_o), 64'(106));
`endif
      check("sub_max", 64'(sub_if.data_o), 64'(64));
      sat_if.in_valid = 1'b0;
      sub_if.in_valid = 1'b0;

      // Reset with three samples in flight
      for (int t = 0; t < 3; t++) begin
         @(negedge clk);
         main_if.in_valid = 1'b1;
         main_if.data_i   = 38'(5000 + t);
      end
      @(negedge clk);
      main_if.in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("midrst_out_valid", 64'(main_if.out_valid), 64'(0));
      check("midrst_data_o", 64'(main_if.data_o), 64'(0));
      check("midrst_in_ready", 64'(main_if.in_ready), 64'(1));
      rst = 1'b0;
      fresh = 38'sd123456;
      main_if.in_valid = 1'b1;
      main_if.data_i   = fresh;
      for (int t = 1; t <= 4; t++) begin
         @(negedge clk);
         main_if.in_valid = 1'b0;
         check("midrst_latency_valid", 64'(main_if.out_valid), 64'(t == 4));
      end
      check("midrst_fresh_data", 64'(main_if.data_o), 64'(gold(fresh)));
      @(negedge clk);
      check("midrst_no_stale", 64'(main_if.out_valid), 64'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
